// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and a
// ceiling-log2 helper for sizing the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: x - y - bin -> difference d, borrow-out bout.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// with a start/busy/done handshake and held results.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  // Counter runs 0..WIDTH so it must hold the value WIDTH itself.
  localparam int CW = clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             dbit;
  logic             borrow_nxt;

  full_subtractor_bit u_fs (
    .x    (areg_q[0]),
    .y    (breg_q[0]),
    .bin  (borrow_q),
    .d    (dbit),
    .bout (borrow_nxt)
  );

  always_comb begin
    state_d  = state_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          areg_d   = a;
          breg_d   = b;
          borrow_d = bin;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // WIDTH shifting cycles, then one settle cycle that publishes the
        // completed result, so partial values never reach d/bout.
        if (cnt_q == CW'(WIDTH)) begin
          d_d     = res_q;
          bout_d  = borrow_q;
          state_d = DONE;
        end else begin
          areg_d   = areg_q >> 1;
          breg_d   = breg_q >> 1;
          res_d    = {dbit, res_q[WIDTH-1:1]};
          borrow_d = borrow_nxt;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      areg_q   <= '0;
      breg_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      areg_q   <= areg_d;
      breg_q   <= breg_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed WIDTH=4 scenarios and a randomized
// back-to-back WIDTH=8 run against an arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, d4;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, d8;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8)
  );

  // Reference model: plain modular arithmetic on integers.
  function automatic int ref_d(input int w, input int a, input int b, input int bin);
    int m;
    m = 1 << w;
    return (((a - b - bin) % m) + m) % m;
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bin);
    return (a < b + bin);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=4 op, scramble inputs after acceptance, wait for done.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output logic [3:0] rd, output logic rb,
                         output int lat, output int busy_n);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    lat = 0; busy_n = 0; rd = 'x; rb = 1'bx;
    while (lat < 20) begin
      if (busy4) busy_n++;
      if (done4) begin
        rd = d4; rb = bout4;
        break;
      end
      tick();
      lat++;
    end
    if (lat >= 20) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; bin4 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    tick(); tick();
    checks++;
    if ({busy4, done4, d4, bout4} !== 7'b0) begin
      errors++;
      $display("FAIL reset4: busy=%b done=%b d=%h bout=%b, want all 0", busy4, done4, d4, bout4);
    end
    checks++;
    if ({busy8, done8, d8, bout8} !== 11'b0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b d=%h bout=%b, want all 0", busy8, done8, d8, bout8);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [3:0] ta[5] = '{4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0000};
    logic [3:0] tb[5] = '{4'b0000, 4'b0000, 4'b0011, 4'b0001, 4'b0000};
    logic       tc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] rd;
    logic       rb;
    int         lat, busy_n;
    for (int i = 0; i < 5; i++) begin
      run_op4(ta[i], tb[i], tc[i], rd, rb, lat, busy_n);
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL directed%0d latency: got %0d cycles, want 5", i, lat);
      end
      checks++;
      if (rd !== 4'(ref_d(4, int'(ta[i]), int'(tb[i]), int'(tc[i])))) begin
        errors++;
        $display("FAIL directed%0d d: got %b, want %b", i, rd,
                 4'(ref_d(4, int'(ta[i]), int'(tb[i]), int'(tc[i]))));
      end
      checks++;
      if (rb !== ref_bout(int'(ta[i]), int'(tb[i]), int'(tc[i]))) begin
        errors++;
        $display("FAIL directed%0d bout: got %b, want %b", i, rb,
                 ref_bout(int'(ta[i]), int'(tb[i]), int'(tc[i])));
      end
      checks++;
      if (busy_n != 6) begin
        errors++;
        $display("FAIL directed%0d busy_cycles: got %0d, want 6", i, busy_n);
      end
      tick();
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d after_done: done=%b busy=%b, want 0 0", i, done4, busy4);
      end
      checks++;
      if (d4 !== rd || bout4 !== rb) begin
        errors++;
        $display("FAIL directed%0d hold: d=%b bout=%b, want %b %b", i, d4, bout4, rd, rb);
      end
    end
  endtask

  task automatic test_ignored_start();
    int         n_done;
    logic [3:0] rd;
    logic       rb;
    a4 = 4'b1000; b4 = 4'b0001; bin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 4'b0011; b4 = 4'b1100; bin4 = 1'b1;
    tick();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n_done = 0; rd = 'x; rb = 1'bx;
    for (int i = 0; i < 25; i++) begin
      if (done4) begin
        n_done++;
        if (n_done == 1) begin
          rd = d4; rb = bout4;
        end
      end
      tick();
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL ignored_start count: got %0d done pulses, want 1", n_done);
    end
    checks++;
    if (rd !== 4'b0111 || rb !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start result: d=%b bout=%b, want 0111 0", rd, rb);
    end
  endtask

  task automatic test_mid_reset();
    int         n_done, lat, busy_n;
    logic [3:0] rd;
    logic       rb;
    a4 = 4'd5; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy4, done4, d4, bout4} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b d=%b bout=%b, want all 0", busy4, done4, d4, bout4);
    end
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done4) n_done++;
      tick();
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL mid_reset no_done: got %0d done pulses, want 0", n_done);
    end
    run_op4(4'd9, 4'd2, 1'b1, rd, rb, lat, busy_n);
    checks++;
    if (lat != 5 || rd !== 4'd6 || rb !== 1'b0) begin
      errors++;
      $display("FAIL post_reset op: lat=%0d d=%0d bout=%b, want 5 6 0", lat, rd, rb);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int         ops, cyc, last_done;
    logic [8:0] e;
    ops = 0; cyc = 0; last_done = -1;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    exp_q.push_back({ref_bout(int'(a8), int'(b8), int'(bin8)),
                     8'(ref_d(8, int'(a8), int'(b8), int'(bin8)))});
    start8 = 1'b1;
    tick(); cyc++;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    while (ops < 200 && cyc < 5000) begin
      if (done8) begin
        e = exp_q.pop_front();
        checks++;
        if (d8 !== e[7:0] || bout8 !== e[8]) begin
          errors++;
          $display("FAIL b2b op%0d: d=%h bout=%b, want %h %b", ops, d8, bout8, e[7:0], e[8]);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != 11) begin
            errors++;
            $display("FAIL b2b spacing op%0d: got %0d cycles, want 11", ops, cyc - last_done);
          end
        end
        last_done = cyc;
        ops++;
        if (ops < 200) begin
          a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1));
          exp_q.push_back({ref_bout(int'(a8), int'(b8), int'(bin8)),
                           8'(ref_d(8, int'(a8), int'(b8), int'(bin8)))});
          tick(); cyc++;
          tick(); cyc++;
          a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        end
      end else begin
        tick(); cyc++;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
    end
    start8 = 1'b0;
    checks++;
    if (ops != 200) begin
      errors++;
      $display("FAIL b2b timeout: got %0d ops, want 200", ops);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b leftover: %0d expected results not seen, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
